hss_tx_framer: RTL and testbench

- Transmit-side framer for the multi-lane source-synchronous HSS link. It runs in the tx divided-clock domain and drives the parallel words for the per-lane 8:1 OSERDESE3 serializers.
- Outputs per cycle: forwarded-clock pattern, one-hot sync word, data-valid lane word, and N data lane bytes.
- Link bring-up: runs a training phase with an incrementing-counter pattern so the receiver gearbox can align and verify, then streams payload from a buffered valid/ready input.
- Idle fill is inserted whenever no payload is available.

---
 rtl/hss_tx_framer.sv | 195 +++++++++++++++++++
 tb/tb_hss_tx_framer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hss_tx_framer.sv
// rtl/hss_tx_framer.sv - HSS transmit framer with OFF/TRAIN/RUN link FSM and payload FIFO; optional HSS_TX_PRBS_EN selects a PRBS7 training pattern
module hss_tx_framer #(
    parameter int         N            = 3,
    parameter int         TRAIN_CYCLES = 256,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] IDLE_BYTE    = 8'hBC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        retrain,
    input  logic [N*8-1:0]              s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [7:0]                  tx_clkpat,
    output logic [7:0]                  tx_sync,
    output logic [7:0]                  tx_dvalid,
    output logic [N*8-1:0]              tx_data,
    output logic [1:0]                  link_state,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] CLK_PAT   = 8'b1010_1010;
    localparam logic [7:0] SYNC_WORD = 8'b0000_0001;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

`ifdef HSS_TX_PRBS_EN
    localparam int            PW       = 7;
    localparam logic [PW-1:0] PAT_SEED = 7'h7F;

    // PRBS7 (x^7+x^6+1) advanced 8 bits; returns {next_state, byte}, first bit in the byte MSB
    function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
        logic [6:0] s;
        logic [7:0] b;
        logic       fb;
        s = seed;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            fb       = s[6] ^ s[5];
            b[7 - k] = fb;
            s        = {s[5:0], fb};
        end
        return {s, b};
    endfunction
`else
    localparam int            PW       = 8;
    localparam logic [PW-1:0] PAT_SEED = 8'h00;
`endif

    state_t         state_q, state_d;
    logic [N*8-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    tcnt_q;
    logic [PW-1:0]  pat_q, pat_d;
    logic [7:0]     pat_byte;
    logic [N*8-1:0] train_word;
    logic           s_ready_q, s_ready_d;
    logic [7:0]     clkpat_q, sync_q, dvalid_q;
    logic [N*8-1:0] data_q;
    logic           push, pop, flush, train_last;

    assign s_ready    = s_ready_q;
    assign tx_clkpat  = clkpat_q;
    assign tx_sync    = sync_q;
    assign tx_dvalid  = dvalid_q;
    assign tx_data    = data_q;
    assign link_state = state_q;
    assign fifo_count = count_q;

    // Training word for the current cycle and the pattern generator's next value
    always_comb begin
`ifdef HSS_TX_PRBS_EN
        {pat_d, pat_byte} = prbs7_step8(pat_q);
`else
        pat_byte = pat_q;
        pat_d    = pat_q + 8'd1;
`endif
        train_word = '0;
        for (int i = 0; i < N; i++) begin
`ifdef HSS_TX_PRBS_EN
            train_word[8*i +: 8] = pat_byte ^ 8'(i);
`else
            train_word[8*i +: 8] = pat_byte;
`endif
        end
    end

    // Next link state, FIFO push/pop/flush decisions and next occupancy
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        flush      = 1'b0;
        push       = s_valid && s_ready_q;
        train_last = (tcnt_q == 16'(TRAIN_CYCLES - 1));
        if (!enable) begin
            state_d = ST_OFF;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_TRAIN;
                ST_TRAIN: if (train_last) state_d = ST_RUN;
                ST_RUN: begin
                    pop = (count_q != '0);
                    if (retrain) state_d = ST_TRAIN;
                end
                default:  state_d = ST_OFF;
            endcase
        end
        count_d   = flush ? '0 : (count_q + CW'(push) - CW'(pop));
        s_ready_d = (state_d != ST_OFF) && (count_d < CW'(FIFO_DEPTH));
    end

    // Payload storage; a flushed write is harmless because the pointers reset
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= s_data;
    end

    // Link FSM, FIFO pointers, training counters and registered serializer words
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tcnt_q    <= '0;
            pat_q     <= PAT_SEED;
            s_ready_q <= 1'b0;
            clkpat_q  <= 8'h00;
            sync_q    <= 8'h00;
            dvalid_q  <= 8'h00;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (!enable) begin
                tcnt_q   <= '0;
                pat_q    <= PAT_SEED;
                clkpat_q <= 8'h00;
                sync_q   <= 8'h00;
                dvalid_q <= 8'h00;
                data_q   <= '0;
            end else begin
                case (state_q)
                    ST_TRAIN: begin
                        tcnt_q   <= tcnt_q + 16'd1;
                        pat_q    <= pat_d;
                        clkpat_q <= CLK_PAT;
                        sync_q   <= SYNC_WORD;
                        dvalid_q <= 8'h00;
                        data_q   <= train_word;
                    end
                    ST_RUN: begin
                        clkpat_q <= CLK_PAT;
                        sync_q   <= SYNC_WORD;
                        if (pop) begin
                            dvalid_q <= 8'hFF;
                            data_q   <= mem[rd_ptr_q];
                        end else begin
                            dvalid_q <= 8'h00;
                            data_q   <= {N{IDLE_BYTE}};
                        end
                        // The pop above still completes; the pattern restarts on the next cycle
                        if (retrain) begin
                            tcnt_q <= '0;
                            pat_q  <= PAT_SEED;
                        end
                    end
                    default: begin
                        tcnt_q   <= '0;
                        pat_q    <= PAT_SEED;
                        clkpat_q <= 8'h00;
                        sync_q   <= 8'h00;
                        dvalid_q <= 8'h00;
                        data_q   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hss_tx_framer.sv
// tb/tb_hss_tx_framer.sv - self-checking bench for hss_tx_framer against a queue-based link model
module tb_hss_tx_framer;
    localparam int N     = 3;
    localparam int TC    = 256;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, enable, retrain, s_valid, s_ready;
    logic [N*8-1:0] s_data, tx_data;
    logic [7:0]    tx_clkpat, tx_sync, tx_dvalid;
    logic [1:0]    link_state;
    logic [$clog2(DEPTH):0] fifo_count;

    hss_tx_framer #(.N(N), .TRAIN_CYCLES(TC), .FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'hBC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .retrain(retrain),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tx_clkpat(tx_clkpat), .tx_sync(tx_sync), .tx_dvalid(tx_dvalid),
        .tx_data(tx_data), .link_state(link_state), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    int             m_state = 0;
    int             m_tcnt = 0;
    int             m_pat = 0;
    logic [23:0]    m_q[$];
    logic [7:0]     e_clk = 0, e_sync = 0, e_dv = 0;
    logic [23:0]    e_data = 0;
    bit             e_ready = 0;
    bit             accepted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_outs();
        e_clk = 8'h00; e_sync = 8'h00; e_dv = 8'h00; e_data = 24'h0;
    endtask

    // One clock: advance the model from the current inputs, then compare after the edge
    task automatic tick();
        logic [23:0] w;
        w = s_data;
        accepted = s_valid && e_ready;
        if (rst) begin
            m_state = 0; m_q.delete(); zero_outs(); accepted = 0;
        end else if (!enable) begin
            m_state = 0; m_q.delete(); zero_outs(); accepted = 0;
        end else begin
            case (m_state)
                0: begin
                    m_state = 1; m_tcnt = 0; m_pat = 0; zero_outs();
                end
                1: begin
                    e_clk = 8'hAA; e_sync = 8'h01; e_dv = 8'h00;
                    e_data = {3{8'(m_pat)}};
                    m_pat = (m_pat + 1) % 256;
                    m_tcnt++;
                    if (m_tcnt == TC) m_state = 2;
                end
                default: begin
                    e_clk = 8'hAA; e_sync = 8'h01;
                    if (m_q.size() > 0) begin
                        e_data = m_q.pop_front(); e_dv = 8'hFF;
                    end else begin
                        e_data = 24'hBCBCBC; e_dv = 8'h00;
                    end
                    if (retrain) begin
                        m_state = 1; m_tcnt = 0; m_pat = 0;
                    end
                end
            endcase
            if (accepted) m_q.push_back(w);
        end
        e_ready = (m_state != 0) && (m_q.size() < DEPTH);
        @(posedge clk);
        #1;
        chk("link_state", 32'(link_state), 32'(m_state));
        chk("s_ready", 32'(s_ready), 32'(e_ready));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("tx_clkpat", 32'(tx_clkpat), 32'(e_clk));
        chk("tx_sync", 32'(tx_sync), 32'(e_sync));
        chk("tx_dvalid", 32'(tx_dvalid), 32'(e_dv));
        chk("tx_data", 32'(tx_data), 32'(e_data));
    endtask

    task automatic push_n(input int n, input int limit, input string tag);
        int got, guard;
        got = 0; guard = 0;
        s_valid = 1'b1; s_data = 24'($urandom());
        while (got < n && guard < limit) begin
            tick();
            guard++;
            if (accepted) begin
                got++;
                s_data = 24'($urandom());
            end
        end
        s_valid = 1'b0;
        chk(tag, 32'(got), 32'(n));
    endtask

    initial begin
        logic [23:0] words [3];
        int guard;
        words[0] = 24'h0A0B0C; words[1] = 24'h1A1B1C; words[2] = 24'h2A2B2C;
        rst = 1'b1; enable = 1'b0; retrain = 1'b0; s_valid = 1'b0; s_data = '0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Training with 17 pushes into a 16-deep FIFO; the 17th waits for RUN
        enable = 1'b1;
        push_n(17, 600, "fill17_accepted");

        // Retrain with 4 words buffered in RUN
        guard = 0;
        while (m_q.size() != 4 && guard < 100) begin tick(); guard++; end
        chk("drain_to_4", 32'(fifo_count), 32'd4);
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        guard = 0;
        while (!(m_state == 2 && m_q.size() == 0) && guard < 600) begin tick(); guard++; end
        chk("retrain_completed", 32'(guard < 600), 32'd1);
        repeat (2) tick();

        // Back-to-back streaming of three directed words
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = words[i];
            guard = 0;
            tick();
            while (!accepted && guard < 20) begin tick(); guard++; end
        end
        s_valid = 1'b0;
        repeat (4) tick();

        // Random payload traffic with occasional retrain pulses
        accepted = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!s_valid || accepted) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 24'($urandom());
            end
            retrain = ($urandom_range(0, 99) == 0);
            tick();
        end
        retrain = 1'b0; s_valid = 1'b0;

        // Disable with 5 words buffered
        enable = 1'b0;
        tick();
        enable = 1'b1;
        push_n(5, 40, "dis_push5");
        enable = 1'b0;
        tick();
        chk("disable_flush", 32'(fifo_count), 32'd0);

        // Reset with 5 words buffered
        enable = 1'b1;
        tick();
        push_n(5, 40, "rst_push5");
        rst = 1'b1;
        tick();
        chk("reset_flush", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
